// File: rtl/fwgpio_irq.sv
// rtl/fwgpio_irq.sv - GPIO input synchronizer, debounce filter and sticky interrupt pending
module fwgpio_irq #(
    parameter int N_PINS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        rt_adr,
    input  logic [31:0]       rt_dat_w,
    output logic [31:0]       rt_dat_r,
    input  logic              rt_we,
    input  logic              rt_valid,
    output logic              rt_ready,
    input  logic [N_PINS-1:0] pin_i,
    output logic              irq
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t state, state_nx;

    logic [N_PINS-1:0] en_q, rise_q, fall_q, level_q, pend_q;
    logic [15:0]       debounce_q;
    logic [15:0]       presc_q;
    logic [N_PINS-1:0] s1_q, s2_q, h0_q, h1_q, filt_q, filt_d_q;

    logic              accept, wr, rd, tick, deb_wr;
    logic [N_PINS-1:0] set, clr, filt_agree;
    logic [31:0]       rd_data;

    // Bus handshake: one accept cycle in IDLE, one ready cycle in ACK
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rt_valid) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rt_ready = (state == ACK);
    end

    assign accept = (state == IDLE) && rt_valid;
    assign wr     = accept && rt_we;
    assign rd     = accept && !rt_we;
    assign deb_wr = wr && (rt_adr == 4'd6);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_q       <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            level_q    <= '0;
            debounce_q <= '0;
        end else if (wr) begin
            case (rt_adr)
                4'd1:    en_q       <= rt_dat_w[N_PINS-1:0];
                4'd2:    rise_q     <= rt_dat_w[N_PINS-1:0];
                4'd3:    fall_q     <= rt_dat_w[N_PINS-1:0];
                4'd4:    level_q    <= rt_dat_w[N_PINS-1:0];
                4'd6:    debounce_q <= rt_dat_w[15:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pin_i;
            s2_q <= s1_q;
        end
    end

    // Prescaler wraps after DEBOUNCE+1 cycles; idle at zero while bypassed
    assign tick = (debounce_q != 16'd0) && (presc_q == debounce_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                      presc_q <= '0;
        else if (deb_wr || debounce_q == 16'd0 || tick)  presc_q <= '0;
        else                                             presc_q <= presc_q + 16'd1;
    end

    // Per bit: all three samples 1 -> 1, all three 0 -> 0, otherwise hold
    assign filt_agree = (s2_q & h0_q & h1_q) | (filt_q & (s2_q | h0_q | h1_q));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h0_q     <= '0;
            h1_q     <= '0;
            filt_q   <= '0;
            filt_d_q <= '0;
        end else begin
            filt_d_q <= filt_q;
            if (debounce_q == 16'd0) begin
                filt_q <= s2_q;
            end else if (tick) begin
                h0_q   <= s2_q;
                h1_q   <= h0_q;
                filt_q <= filt_agree;
            end
        end
    end

    assign set = (rise_q & filt_q & ~filt_d_q)
               | (fall_q & ~filt_q & filt_d_q)
               | (level_q & filt_q);
    assign clr = (wr && rt_adr == 4'd5) ? rt_dat_w[N_PINS-1:0] : '0;

    // Set is OR-ed after the clear so a same-cycle event is never lost
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            irq    <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~clr) | set;
            irq    <= |(pend_q & en_q);
        end
    end

    always_comb begin
        rd_data = '0;
        case (rt_adr)
            4'd0:    rd_data = 32'(filt_q);
            4'd1:    rd_data = 32'(en_q);
            4'd2:    rd_data = 32'(rise_q);
            4'd3:    rd_data = 32'(fall_q);
            4'd4:    rd_data = 32'(level_q);
            4'd5:    rd_data = 32'(pend_q);
            4'd6:    rd_data = 32'(debounce_q);
            default: rd_data = '0;
        endcase
    end

    // Read data is loaded at accept, visible during ACK, zero otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rt_dat_r <= '0;
        else        rt_dat_r <= rd ? rd_data : '0;
    end

endmodule
